// File: rtl/efuse_macro_seq_if.sv
// Controller/macro-facing signal bundle of the eFuse timing sequencer.
interface efuse_macro_seq_if #(
  parameter int unsigned NW = 64,
  parameter int unsigned NR = 64
);
  localparam int unsigned RSW = (256 / NR > 1) ? $clog2(256 / NR) : 1;
  localparam int unsigned WSW = (256 / NW > 1) ? $clog2(256 / NW) : 1;

  // controller side
  logic           read_start;
  logic [RSW-1:0] efuse_read_sel;
  logic           read_done;
  logic [NR-1:0]  read_data;
  logic           efuse_busy_read;
  logic           write_start;
  logic [WSW-1:0] efuse_write_sel;
  logic [NW-1:0]  write_data;
  logic           write_done;
  logic           efuse_busy_write;

  // hard macro side
  logic           efuse_csb;
  logic           efuse_pgenb;
  logic           efuse_load;
  logic           efuse_strobe;
  logic [7:0]     efuse_addr;
  logic [7:0]     efuse_q;

  modport master (
    output read_start, efuse_read_sel, write_start, efuse_write_sel, write_data, efuse_q,
    input  read_done, read_data, efuse_busy_read, write_done, efuse_busy_write,
    input  efuse_csb, efuse_pgenb, efuse_load, efuse_strobe, efuse_addr
  );

  modport slave (
    input  read_start, efuse_read_sel, write_start, efuse_write_sel, write_data, efuse_q,
    output read_done, read_data, efuse_busy_read, write_done, efuse_busy_write,
    output efuse_csb, efuse_pgenb, efuse_load, efuse_strobe, efuse_addr
  );
endinterface

// File: rtl/efuse_macro_seq.sv
// eFuse hard-macro timing sequencer: byte-wise reads assembled into NR-bit
// words, bit-serial programming of the '1' bits of an NW-bit word.
module efuse_macro_seq #(
  parameter int unsigned NW           = 64,
  parameter int unsigned NR           = 64,
  parameter int unsigned T_SETUP      = 2,
  parameter int unsigned T_RD_STROBE  = 4,
  parameter int unsigned T_PGM_STROBE = 200,
  parameter int unsigned T_HOLD       = 2
) (
  input logic             clk,
  input logic             rst_n,
  efuse_macro_seq_if.slave bus
);

  localparam int unsigned NBYTES = NR / 8;
  localparam int unsigned TMAX_A = (T_SETUP > T_RD_STROBE) ? T_SETUP : T_RD_STROBE;
  localparam int unsigned TMAX_B = (T_PGM_STROBE > T_HOLD) ? T_PGM_STROBE : T_HOLD;
  localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int unsigned CW     = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    IDLE, RD_SETUP, RD_STB, RD_HOLD, WR_SETUP, WR_STB, WR_HOLD, WR_SKIP, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     base_q, base_d;
  logic           is_rd_q, is_rd_d;
  logic [NW-1:0]  wdata_q, wdata_d;
  logic [NR-1:0]  shadow_q, shadow_d;
  logic           wr_next;

  logic           csb_q, csb_d;
  logic           pgenb_q, pgenb_d;
  logic           load_q, load_d;
  logic           strobe_q, strobe_d;
  logic [7:0]     addr_q, addr_d;
  logic [NR-1:0]  read_data_q, read_data_d;
  logic           read_done_q, read_done_d;
  logic           write_done_q, write_done_d;
  logic           busy_rd_q, busy_rd_d;
  logic           busy_wr_q, busy_wr_d;

  // State, sequencing context and registered macro/controller outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      base_q       <= '0;
      is_rd_q      <= 1'b0;
      wdata_q      <= '0;
      shadow_q     <= '0;
      csb_q        <= 1'b1;
      pgenb_q      <= 1'b1;
      load_q       <= 1'b0;
      strobe_q     <= 1'b0;
      addr_q       <= '0;
      read_data_q  <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      busy_rd_q    <= 1'b0;
      busy_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      is_rd_q      <= is_rd_d;
      wdata_q      <= wdata_d;
      shadow_q     <= shadow_d;
      csb_q        <= csb_d;
      pgenb_q      <= pgenb_d;
      load_q       <= load_d;
      strobe_q     <= strobe_d;
      addr_q       <= addr_d;
      read_data_q  <= read_data_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
      busy_rd_q    <= busy_rd_d;
      busy_wr_q    <= busy_wr_d;
    end
  end

  // Next-state, phase counting, and outputs derived from the next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    base_d   = base_q;
    is_rd_d  = is_rd_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    wr_next  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.read_start) begin
          state_d = RD_SETUP;
          base_d  = 8'(bus.efuse_read_sel) * 8'(NBYTES);
          idx_d   = '0;
          is_rd_d = 1'b1;
        end else if (bus.write_start) begin
          state_d = bus.write_data[0] ? WR_SETUP : WR_SKIP;
          base_d  = 8'(bus.efuse_write_sel) * 8'(NW);
          idx_d   = '0;
          is_rd_d = 1'b0;
          wdata_d = bus.write_data;
        end
      end
      RD_SETUP: if (cnt_q == CW'(T_SETUP - 1)) begin
        state_d = RD_STB;
        cnt_d   = '0;
      end
      RD_STB: if (cnt_q == CW'(T_RD_STROBE - 1)) begin
        // New byte enters at the top; after NBYTES shifts byte 0 sits at the bottom.
        state_d  = RD_HOLD;
        cnt_d    = '0;
        shadow_d = (shadow_q >> 8) | (NR'(bus.efuse_q) << (NR - 8));
      end
      RD_HOLD: if (cnt_q == CW'(T_HOLD - 1)) begin
        cnt_d = '0;
        if (idx_q == 8'(NBYTES - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = RD_SETUP;
        end
      end
      WR_SETUP: if (cnt_q == CW'(T_SETUP - 1)) begin
        state_d = WR_STB;
        cnt_d   = '0;
      end
      WR_STB: if (cnt_q == CW'(T_PGM_STROBE - 1)) begin
        state_d = WR_HOLD;
        cnt_d   = '0;
      end
      WR_HOLD: if (cnt_q == CW'(T_HOLD - 1)) wr_next = 1'b1;
      WR_SKIP: wr_next = 1'b1;
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Advance to the next write bit; wdata is shifted so bit 0 is always current.
    if (wr_next) begin
      cnt_d = '0;
      if (idx_q == 8'(NW - 1)) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 8'd1;
        wdata_d = wdata_q >> 1;
        state_d = wdata_d[0] ? WR_SETUP : WR_SKIP;
      end
    end

    csb_d        = (state_d == IDLE) || (state_d == DONE);
    pgenb_d      = !(state_d inside {WR_SETUP, WR_STB, WR_HOLD, WR_SKIP});
    load_d       = state_d inside {RD_SETUP, RD_STB, RD_HOLD};
    strobe_d     = state_d inside {RD_STB, WR_STB};
    addr_d       = csb_d ? addr_q : (base_d + idx_d);
    read_done_d  = (state_d == DONE) && is_rd_d;
    write_done_d = (state_d == DONE) && !is_rd_d;
    busy_rd_d    = (state_d != IDLE) && is_rd_d;
    busy_wr_d    = (state_d != IDLE) && !is_rd_d;
    read_data_d  = read_done_d ? shadow_q : read_data_q;
  end

  assign bus.efuse_csb        = csb_q;
  assign bus.efuse_pgenb      = pgenb_q;
  assign bus.efuse_load       = load_q;
  assign bus.efuse_strobe     = strobe_q;
  assign bus.efuse_addr       = addr_q;
  assign bus.read_data        = read_data_q;
  assign bus.read_done        = read_done_q;
  assign bus.write_done       = write_done_q;
  assign bus.efuse_busy_read  = busy_rd_q;
  assign bus.efuse_busy_write = busy_wr_q;

endmodule

// File: tb/tb_efuse_macro_seq.sv
// Bench for efuse_macro_seq: fuse-array macro model, scoreboard of expected
// completions, randomized read/program traffic.
module tb_efuse_macro_seq;
  localparam int unsigned NW  = 64;
  localparam int unsigned NR  = 64;
  localparam int unsigned TS  = 2;
  localparam int unsigned TRD = 4;
  localparam int unsigned TPG = 200;
  localparam int unsigned TH  = 2;
  localparam int unsigned NB  = NR / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  efuse_macro_seq_if #(.NW(NW), .NR(NR)) bus ();

  efuse_macro_seq #(
    .NW(NW), .NR(NR), .T_SETUP(TS), .T_RD_STROBE(TRD), .T_PGM_STROBE(TPG), .T_HOLD(TH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          is_rd;
    int unsigned base;      // byte address for reads, bit address for writes
    logic [63:0] data;      // expected word for reads, programmed bits for writes
    int unsigned done_cyc;
  } item_t;

  typedef struct {
    int unsigned addr;
    int unsigned width;
    logic        pgenb;
    logic        load;
  } stb_t;

  item_t       sb[$];
  stb_t        slog[$];
  stb_t        exp_q[$];
  item_t       it_m;
  stb_t        stb_cur;
  int unsigned stb_w = 0;
  logic [255:0] fuse_hw;
  logic [255:0] fuse_ref;
  logic [63:0] last_rd_exp = '0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          cur_rd = 1'b0;
  bit          cur_wr = 1'b0;
  int unsigned cur_start = 0;
  int unsigned cur_end = 0;

  assign bus.efuse_q = fuse_hw[{bus.efuse_addr[4:0], 3'b000} +: 8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Macro model, per-cycle control expectations, and completion scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      stb_w = 0;  // a strobe cut by reset never programs a fuse
    end else begin
      if (bus.efuse_strobe) begin
        if (stb_w == 0) begin
          stb_cur.addr  = 32'(bus.efuse_addr);
          stb_cur.pgenb = bus.efuse_pgenb;
          stb_cur.load  = bus.efuse_load;
        end else begin
          chk("addr_stable_in_strobe", 64'(bus.efuse_addr), 64'(stb_cur.addr));
          chk("pgenb_stable_in_strobe", 64'(bus.efuse_pgenb), 64'(stb_cur.pgenb));
          chk("load_stable_in_strobe", 64'(bus.efuse_load), 64'(stb_cur.load));
        end
        chk("csb_low_in_strobe", 64'(bus.efuse_csb), 64'(0));
        stb_w++;
      end else if (stb_w != 0) begin
        stb_cur.width = stb_w;
        slog.push_back(stb_cur);
        if (!stb_cur.pgenb && !stb_cur.load && stb_w >= TPG) fuse_hw[8'(stb_cur.addr)] = 1'b1;
        stb_w = 0;
      end

      chk("busy_read", 64'(bus.efuse_busy_read), 64'(cur_rd && cyc > cur_start && cyc <= cur_end));
      chk("busy_write", 64'(bus.efuse_busy_write), 64'(cur_wr && cyc > cur_start && cyc <= cur_end));
      if (cyc > cur_start && cyc < cur_end) begin
        chk("csb_in_op", 64'(bus.efuse_csb), 64'(0));
        chk("pgenb_in_op", 64'(bus.efuse_pgenb), 64'(cur_rd));
        chk("load_in_op", 64'(bus.efuse_load), 64'(cur_rd));
      end else begin
        chk("csb_idle", 64'(bus.efuse_csb), 64'(1));
        chk("pgenb_idle", 64'(bus.efuse_pgenb), 64'(1));
        chk("load_idle", 64'(bus.efuse_load), 64'(0));
      end

      if (bus.read_done || bus.write_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: read_done=%0b write_done=%0b with nothing outstanding (cycle %0d)",
                   bus.read_done, bus.write_done, cyc);
        end else begin
          it_m = sb.pop_front();
          chk("done_kind", 64'(bus.read_done), 64'(it_m.is_rd));
          chk("done_both", 64'(bus.read_done && bus.write_done), 64'(0));
          chk("done_cycle", 64'(cyc), 64'(it_m.done_cyc));
          exp_q.delete();
          if (it_m.is_rd) begin
            chk("read_data", bus.read_data, it_m.data);
            last_rd_exp = it_m.data;
            for (int i = 0; i < int'(NB); i++)
              exp_q.push_back('{addr: it_m.base + 32'(i), width: TRD, pgenb: 1'b1, load: 1'b1});
          end else begin
            for (int i = 0; i < int'(NW); i++)
              if (it_m.data[i]) exp_q.push_back('{addr: it_m.base + 32'(i), width: TPG, pgenb: 1'b0, load: 1'b0});
          end
          chk("strobe_count", 64'(slog.size()), 64'(exp_q.size()));
          for (int i = 0; i < exp_q.size() && i < slog.size(); i++) begin
            chk("strobe_addr", 64'(slog[i].addr), 64'(exp_q[i].addr));
            chk("strobe_width", 64'(slog[i].width), 64'(exp_q[i].width));
            chk("strobe_pgenb", 64'(slog[i].pgenb), 64'(exp_q[i].pgenb));
          end
          slog.delete();
          if (!it_m.is_rd)
            for (int i = 0; i < int'(NW); i++) if (it_m.data[i]) fuse_ref[it_m.base + 32'(i)] = 1'b1;
        end
      end else begin
        chk("read_data_stable", bus.read_data, last_rd_exp);
      end
    end
  end

  // Issue one accepted request, record its expected completion, then poke ignored starts
  task automatic issue(input bit rd, input int unsigned sel, input logic [63:0] data, input bit both);
    item_t it;
    int unsigned cost;
    @(posedge clk);
    #1;
    bus.read_start      = rd || both;
    bus.write_start     = !rd || both;
    bus.efuse_read_sel  = 2'(sel);
    bus.efuse_write_sel = 2'(sel);
    bus.write_data      = data;
    it.is_rd = rd || both;
    if (it.is_rd) begin
      it.base     = sel * NB;
      it.data     = fuse_ref[sel * NR +: 64];
      it.done_cyc = cyc + 1 + NB * (TS + TRD + TH);
    end else begin
      cost = 0;
      for (int i = 0; i < int'(NW); i++) cost += data[i] ? (TS + TPG + TH) : 1;
      it.base     = sel * NW;
      it.data     = data;
      it.done_cyc = cyc + 1 + cost;
    end
    cur_rd    = it.is_rd;
    cur_wr    = !it.is_rd;
    cur_start = cyc;
    cur_end   = it.done_cyc;
    sb.push_back(it);
    @(posedge clk);
    #1;
    bus.read_start      = 1'b0;
    bus.write_start     = 1'b0;
    bus.write_data      = {$urandom, $urandom};
    bus.efuse_read_sel  = 2'($urandom);
    bus.efuse_write_sel = 2'($urandom);
    @(posedge clk);
    #1;
    bus.read_start  = 1'($urandom);
    bus.write_start = 1'b1;
    bus.write_data  = {$urandom, $urandom};
    @(posedge clk);
    #1;
    bus.read_start  = 1'b0;
    bus.write_start = 1'b0;
  endtask

  // Wait for the outstanding request's done pulse, bounded
  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.read_done || bus.write_done) break;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    bus.read_start      = 1'b1;
    bus.write_start     = 1'b1;
    bus.efuse_read_sel  = 2'd1;
    bus.efuse_write_sel = 2'd1;
    bus.write_data      = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int b = 0; b < 32; b++) fuse_hw[8 * b +: 8] = 8'(b);
    fuse_ref = fuse_hw;

    // Reset with starts asserted
    repeat (3) @(negedge clk);
    chk("rst_csb", 64'(bus.efuse_csb), 64'(1));
    chk("rst_pgenb", 64'(bus.efuse_pgenb), 64'(1));
    chk("rst_load", 64'(bus.efuse_load), 64'(0));
    chk("rst_strobe", 64'(bus.efuse_strobe), 64'(0));
    chk("rst_addr", 64'(bus.efuse_addr), 64'(0));
    chk("rst_busy_read", 64'(bus.efuse_busy_read), 64'(0));
    chk("rst_busy_write", 64'(bus.efuse_busy_write), 64'(0));
    chk("rst_read_done", 64'(bus.read_done), 64'(0));
    chk("rst_write_done", 64'(bus.write_done), 64'(0));
    chk("rst_read_data", bus.read_data, 64'(0));
    bus.read_start  = 1'b0;
    bus.write_start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single read of word 2, then back-to-back reads of all words
    issue(1'b1, 2, 64'd0, 1'b0);
    wait_done(200);
    for (int s = 0; s < 4; s++) begin
      issue(1'b1, 32'(s), 64'd0, 1'b0);
      wait_done(200);
    end

    // Program two bits of word 1, then a write with nothing to program
    issue(1'b0, 1, 64'h5, 1'b0);
    wait_done(1000);
    issue(1'b0, 2, 64'h0, 1'b0);
    wait_done(200);

    // Simultaneous starts: read of word 1 wins
    issue(1'b1, 1, 64'hFFFF_0000_FFFF_0000, 1'b1);
    wait_done(200);

    // Reset in the middle of a program strobe
    issue(1'b0, 3, 64'h1, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_strobe_async", 64'(bus.efuse_strobe), 64'(0));
    chk("reset_csb_async", 64'(bus.efuse_csb), 64'(1));
    sb.delete();
    cur_rd = 1'b0;
    cur_wr = 1'b0;
    cur_end = 0;
    last_rd_exp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    issue(1'b1, 3, 64'd0, 1'b0);
    wait_done(200);

    // Randomized traffic
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 1) == 0) begin
        issue(1'b1, $urandom_range(0, 3), 64'd0, 1'($urandom_range(0, 3) == 0));
      end else begin
        d = '0;
        repeat ($urandom_range(0, 3)) d[$urandom_range(0, 63)] = 1'b1;
        issue(1'b0, $urandom_range(0, 3), d, 1'b0);
      end
      wait_done(1000);
    end
    for (int s = 0; s < 4; s++) begin
      issue(1'b1, 32'(s), 64'd0, 1'b0);
      wait_done(200);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
